// File: rtl/fix_msg_parse.sv
// Byte-serial FIX field parser: splits tag=value<SOH> fields and verifies the 10=nnn checksum trailer.
// Optional build macro FIX_PARSE_STRICT_TAG_EN rejects tag bytes outside '0'..'9'.
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 64
`endif

module fix_msg_parse #(
  parameter int VALUE_WIDTH = `VALUE_DATA_WIDTH,
  parameter int T_SIZE      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               data_i,
  input  logic                     data_valid_i,
  output logic [31:0]              tag_o,
  output logic [T_SIZE-1:0]        t_size_o,
  output logic [VALUE_WIDTH-1:0]   val_o,
  output logic [VALUE_WIDTH/8-1:0] v_size_o,
  output logic                     field_valid_o,
  output logic                     msg_done_o,
  output logic                     chk_ok_o,
  output logic                     chk_err_o,
  output logic                     err_o
);

  localparam int V_BYTES = VALUE_WIDTH / 8;
  localparam int VC_W    = $clog2(V_BYTES + 1);
  localparam logic [7:0] EQ   = 8'h3d;
  localparam logic [7:0] SOH  = 8'h01;
  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] NINE = 8'h39;

  typedef enum logic [1:0] {S_TAG, S_VAL, S_CSUM, S_SKIP} state_t;

  state_t                 state, state_n;
  logic [31:0]            tag_buf, tag_buf_n;
  logic [2:0]             tcnt, tcnt_n;
  logic [VALUE_WIDTH-1:0] val_buf, val_buf_n;
  logic [VC_W-1:0]        vcnt, vcnt_n;
  logic [7:0]             sum_run, sum_run_n, sum_cmt, sum_cmt_n, sum_add;
  logic [9:0]             acc, acc_n;
  logic [1:0]             dcnt, dcnt_n;
  logic                   bad, bad_n;
  logic                   field_n, done_n, ok_n, cerr_n, err_n, clr_field;
  logic                   is_digit, tag_byte_bad;
  logic [7:0]             digit;
  logic [T_SIZE-1:0]      t_mask;
  logic [V_BYTES-1:0]     v_mask;

  assign is_digit = (data_i >= ZERO) && (data_i <= NINE);
  assign digit    = data_i - ZERO;
  assign sum_add  = sum_run + data_i;

`ifdef FIX_PARSE_STRICT_TAG_EN
  assign tag_byte_bad = !is_digit;
`else
  assign tag_byte_bad = 1'b0;
`endif

  always_comb begin
    for (int k = 0; k < T_SIZE; k++) t_mask[k] = (tcnt > 3'(k));
    for (int k = 0; k < V_BYTES; k++) v_mask[k] = (vcnt > VC_W'(k));
  end

  always_comb begin
    // NOTE: every signal gets its hold/idle value first so no path can infer a latch.
    state_n   = state;
    tag_buf_n = tag_buf;
    tcnt_n    = tcnt;
    val_buf_n = val_buf;
    vcnt_n    = vcnt;
    sum_run_n = sum_run;
    sum_cmt_n = sum_cmt;
    acc_n     = acc;
    dcnt_n    = dcnt;
    bad_n     = bad;
    field_n   = 1'b0;
    done_n    = 1'b0;
    ok_n      = 1'b0;
    cerr_n    = 1'b0;
    err_n     = 1'b0;
    clr_field = 1'b0;

    if (data_valid_i) begin
      case (state)
        S_TAG: begin
          sum_run_n = sum_add;
          if (data_i == EQ) begin
            if (tcnt == 3'd0) begin
              err_n   = 1'b1;
              state_n = S_SKIP;
            end else if (tag_buf == 32'h0000_3031) begin
              state_n = S_CSUM;
            end else begin
              state_n = S_VAL;
            end
          end else if (tcnt == 3'(T_SIZE) || tag_byte_bad) begin
            err_n   = 1'b1;
            state_n = S_SKIP;
          end else begin
            for (int k = 0; k < T_SIZE; k++)
              if (tcnt == 3'(k)) tag_buf_n[k*8 +: 8] = data_i;
            tcnt_n = tcnt + 3'd1;
          end
        end

        S_VAL: begin
          sum_run_n = sum_add;
          if (data_i == SOH) begin
            if (vcnt == '0) begin
              err_n   = 1'b1;
              state_n = S_SKIP;
            end else begin
              field_n   = 1'b1;
              sum_cmt_n = sum_add;
              clr_field = 1'b1;
              state_n   = S_TAG;
            end
          end else if (vcnt == VC_W'(V_BYTES)) begin
            err_n   = 1'b1;
            state_n = S_SKIP;
          end else begin
            for (int k = 0; k < V_BYTES; k++)
              if (vcnt == VC_W'(k)) val_buf_n[k*8 +: 8] = data_i;
            vcnt_n = vcnt + VC_W'(1);
          end
        end

        S_SKIP: begin
          sum_run_n = sum_add;
          if (data_i == SOH) begin
            sum_cmt_n = sum_add;
            clr_field = 1'b1;
            state_n   = S_TAG;
          end
        end

        S_CSUM: begin
          if (data_i == SOH) begin
            done_n    = 1'b1;
            ok_n      = (dcnt == 2'd3) && !bad && (acc == {2'b00, sum_cmt});
            cerr_n    = !ok_n;
            sum_run_n = '0;
            sum_cmt_n = '0;
            acc_n     = '0;
            dcnt_n    = '0;
            bad_n     = 1'b0;
            clr_field = 1'b1;
            state_n   = S_TAG;
          end else if (is_digit && dcnt != 2'd3) begin
            // At most two digits precede this one, so acc*10 stays below 1000.
            acc_n  = acc * 10'd10 + {2'b00, digit};
            dcnt_n = dcnt + 2'd1;
          end else begin
            bad_n = 1'b1;
          end
        end

        default: state_n = S_TAG;
      endcase
    end

    if (clr_field) begin
      tag_buf_n = '0;
      tcnt_n    = '0;
      val_buf_n = '0;
      vcnt_n    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_TAG;
      tag_buf       <= '0;
      tcnt          <= '0;
      val_buf       <= '0;
      vcnt          <= '0;
      sum_run       <= '0;
      sum_cmt       <= '0;
      acc           <= '0;
      dcnt          <= '0;
      bad           <= 1'b0;
      tag_o         <= '0;
      t_size_o      <= '0;
      val_o         <= '0;
      v_size_o      <= '0;
      field_valid_o <= 1'b0;
      msg_done_o    <= 1'b0;
      chk_ok_o      <= 1'b0;
      chk_err_o     <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state         <= state_n;
      tag_buf       <= tag_buf_n;
      tcnt          <= tcnt_n;
      val_buf       <= val_buf_n;
      vcnt          <= vcnt_n;
      sum_run       <= sum_run_n;
      sum_cmt       <= sum_cmt_n;
      acc           <= acc_n;
      dcnt          <= dcnt_n;
      bad           <= bad_n;
      field_valid_o <= field_n;
      msg_done_o    <= done_n;
      chk_ok_o      <= ok_n;
      chk_err_o     <= cerr_n;
      err_o         <= err_n;
      if (field_n) begin
        tag_o    <= tag_buf;
        t_size_o <= t_mask;
        val_o    <= val_buf;
        v_size_o <= v_mask;
      end
    end
  end

endmodule

// File: tb/tb_fix_msg_parse.sv
// Self-checking bench for fix_msg_parse: string-level field model plus hand-computed expectations.
`timescale 1ns/1ps

module tb_fix_msg_parse;

  localparam int VW = 32;
  localparam int VB = VW / 8;
  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EQ  = 8'h3d;
`ifdef FIX_PARSE_STRICT_TAG_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    data_i;
  logic          data_valid_i;
  logic [31:0]   tag_o;
  logic [3:0]    t_size_o;
  logic [VW-1:0] val_o;
  logic [VB-1:0] v_size_o;
  logic          field_valid_o, msg_done_o, chk_ok_o, chk_err_o, err_o;

  fix_msg_parse #(.VALUE_WIDTH(VW), .T_SIZE(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .tag_o         (tag_o),
    .t_size_o      (t_size_o),
    .val_o         (val_o),
    .v_size_o      (v_size_o),
    .field_valid_o (field_valid_o),
    .msg_done_o    (msg_done_o),
    .chk_ok_o      (chk_ok_o),
    .chk_err_o     (chk_err_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_field = 0, cnt_done = 0, cnt_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- model: works on the text of the current field ----------------
  logic [7:0]    cur[$];
  bit            skipping;
  int            pend, body_sum;
  logic [31:0]   e_tag;
  logic [3:0]    e_tsz;
  logic [VW-1:0] e_val;
  logic [VB-1:0] e_vsz;
  bit            e_field, e_done, e_ok, e_cerr, e_err;

  function automatic bit is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  task automatic model_reset();
    cur.delete();
    skipping = 1'b0; pend = 0; body_sum = 0;
    e_tag = '0; e_tsz = '0; e_val = '0; e_vsz = '0;
    e_field = 0; e_done = 0; e_ok = 0; e_cerr = 0; e_err = 0;
  endtask

  task automatic model_error();
    e_err = 1'b1;
    skipping = 1'b1;
    cur.delete();
  endtask

  task automatic model_step(input logic [7:0] b, input bit v);
    int eq;
    bit trailer;
    e_field = 0; e_done = 0; e_ok = 0; e_cerr = 0; e_err = 0;
    if (!v) return;
    if (skipping) begin
      pend = (pend + b) % 256;
      if (b == SOH) begin
        body_sum = pend;
        skipping = 1'b0;
        cur.delete();
      end
      return;
    end
    cur.push_back(b);
    eq = -1;
    for (int i = 0; i < cur.size(); i++)
      if (cur[i] == EQ) begin eq = i; break; end
    if (eq < 0) begin
      pend = (pend + b) % 256;
      if (cur.size() > 4 || (STRICT && !is_dig(b))) model_error();
      return;
    end
    trailer = (eq == 2) && (cur[0] == 8'h31) && (cur[1] == 8'h30);
    if (eq == cur.size() - 1) begin
      pend = (pend + b) % 256;
      if (eq == 0) model_error();
      return;
    end
    if (trailer) begin
      if (b == SOH) begin
        int n, val;
        bit good;
        n = cur.size() - 4;
        val = 0;
        good = (n == 3);
        for (int i = 3; i < cur.size() - 1; i++)
          if (is_dig(cur[i])) val = val * 10 + (cur[i] - 8'h30);
          else good = 1'b0;
        good = good && (val == body_sum);
        e_done = 1'b1; e_ok = good; e_cerr = !good;
        body_sum = 0; pend = 0;
        cur.delete();
      end
      return;
    end
    pend = (pend + b) % 256;
    if (b == SOH) begin
      int n;
      n = cur.size() - eq - 2;
      if (n == 0) model_error();
      else begin
        e_field = 1'b1;
        e_tag = '0; e_val = '0;
        for (int k = 0; k < 4; k++)  e_tsz[k] = (k < eq);
        for (int k = 0; k < VB; k++) e_vsz[k] = (k < n);
        for (int k = 0; k < eq; k++) e_tag[k*8 +: 8] = cur[k];
        for (int k = 0; k < n; k++)  e_val[k*8 +: 8] = cur[eq + 1 + k];
        body_sum = pend;
        cur.delete();
      end
    end else if (cur.size() - eq - 1 > VB) begin
      model_error();
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("field_valid_o", field_valid_o, e_field);
      check("msg_done_o",    msg_done_o,    e_done);
      check("chk_ok_o",      chk_ok_o,      e_ok);
      check("chk_err_o",     chk_err_o,     e_cerr);
      check("err_o",         err_o,         e_err);
      check("tag_o",         tag_o,         e_tag);
      check("t_size_o",      t_size_o,      e_tsz);
      check("val_o",         val_o,         e_val);
      check("v_size_o",      v_size_o,      e_vsz);
      if (field_valid_o === 1'b1) cnt_field++;
      if (msg_done_o === 1'b1)    cnt_done++;
      if (err_o === 1'b1)         cnt_err++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] b, input bit v);
    data_i = b;
    data_valid_i = v;
    @(posedge clk);
    model_step(b, v);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0);
  endtask

  // '|' stands for SOH in stimulus strings.
  task automatic send(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s[i];
      if (c == 8'h7c) c = SOH;
      drive(c, 1'b1);
      if (gaps) drive(8'hff, 1'b0);
    end
  endtask

  initial begin
    int f0, e0, d0;
    rst = 1'b0;
    data_i = '0;
    data_valid_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset tag_o", tag_o, 32'h0);
    check("reset val_o", val_o, 32'h0);
    check("reset pulses", {field_valid_o, msg_done_o, chk_ok_o, chk_err_o, err_o}, 5'b0);
    check("reset sizes", {t_size_o, v_size_o}, 8'h0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Good trailer: 8=A| sums to 0xB7 = 183.
    send("8=A|", 1'b0);
    check("8=A tag", tag_o, 32'h0000_0038);
    check("8=A val", val_o, 32'h0000_0041);
    send("10=183|", 1'b0);
    check("183 done", msg_done_o, 1'b1);
    check("183 ok", chk_ok_o, 1'b1);
    check("183 err", chk_err_o, 1'b0);

    send("8=A|10=184|", 1'b0);
    check("184 done", msg_done_o, 1'b1);
    check("184 chk_err", chk_err_o, 1'b1);
    send("8=A|10=18|", 1'b0);
    check("2-digit chk_err", chk_err_o, 1'b1);

    send("35=A|", 1'b0);
    check("35=A field", field_valid_o, 1'b1);
    check("35=A tag", tag_o, 32'h0000_3533);
    check("35=A t_size", t_size_o, 4'b0011);
    check("35=A val", val_o, 32'h0000_0041);
    check("35=A v_size", v_size_o, 4'b0001);
    send("10=231|", 1'b0);
    check("231 ok", chk_ok_o, 1'b1);

    // Malformed fields; their bytes still count towards the checksum (total 214).
    f0 = cnt_field; e0 = cnt_err;
    send("=X|", 1'b0);
    send("12345=X|", 1'b0);
    send("7=ABCDE|", 1'b0);
    idle(1);
    check("err pulses", cnt_err - e0, 3);
    check("no field on err", cnt_field - f0, 0);
    send("35=A|", 1'b0);
    check("recover tag", tag_o, 32'h0000_3533);
    check("recover val", val_o, 32'h0000_0041);
    send("10=214|", 1'b0);
    check("214 ok", chk_ok_o, 1'b1);

    // Full-width tag and value, then a 4-digit trailer.
    send("1234=WXYZ|", 1'b0);
    check("wide tag", tag_o, 32'h3433_3231);
    check("wide t_size", t_size_o, 4'b1111);
    check("wide val", val_o, 32'h5a59_5857);
    check("wide v_size", v_size_o, 4'b1111);
    d0 = cnt_done;
    send("10=0183|", 1'b0);
    check("4-digit chk_err", chk_err_o, 1'b1);
    idle(1);
    check("one done", cnt_done - d0, 1);

    // Valid toggling every cycle.
    f0 = cnt_field;
    send("49=ABC|", 1'b1);
    idle(1);
    check("gap field count", cnt_field - f0, 1);
    check("gap tag", tag_o, 32'h0000_3934);
    check("gap t_size", t_size_o, 4'b0011);
    check("gap val", val_o, 32'h0043_4241);
    check("gap v_size", v_size_o, 4'b0111);

    // Asynchronous reset mid-field.
    send("35=A", 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid-rst tag", tag_o, 32'h0);
    check("mid-rst val", val_o, 32'h0);
    check("mid-rst sizes", {t_size_o, v_size_o}, 8'h0);
    model_reset();
    idle(2);
    #2 rst = 1'b1;
    send("8=B|", 1'b0);
    check("post-rst field", field_valid_o, 1'b1);
    check("post-rst tag", tag_o, 32'h0000_0038);
    check("post-rst val", val_o, 32'h0000_0042);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
